// File: rtl/mmio_spi_ctrl.sv
// FIFO-buffered SPI master on the OTTER IOBUS: TXDATA/RXDATA/STATUS/CTRL window.
// Optional SPI_LOOPBACK_EN adds CTRL[24] LOOP, feeding SDO back into the receiver.
module mmio_spi_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h1120_0000,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          NUM_CS     = 1,
    parameter logic [15:0] RESET_DIV  = 16'd49
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       IOBUS_ADDR,
    input  logic [31:0]       IOBUS_OUT,
    input  logic              IOBUS_WR,
    output logic [31:0]       IOBUS_IN,
    output logic              SPI_SCLK,
    output logic              SPI_SDO,
    input  logic              SPI_SDI,
    output logic [NUM_CS-1:0] SPI_CS
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_LAST, S_GAP} state_t;

    state_t              r_state;
    logic [15:0]         r_div, r_div_l, r_hcnt;
    logic                r_cpol, r_cpha, r_cpha_l, r_en;
    logic [3:0]          r_cs_sel;
    logic                r_tx_ovf, r_rx_ovf;
    logic                r_sclk, r_sdo;
    logic [NUM_CS-1:0]   r_cs;
    logic [DATA_W-1:0]   r_tx, r_rx;
    logic [6:0]          r_tog;

    logic [DATA_W-1:0]   r_tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [CW-1:0]       r_tx_cnt, r_rx_cnt;

    logic w_sel_tx, w_sel_rx, w_sel_st, w_sel_ctrl;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_done;
    logic w_hdone, w_loop, w_sin, w_sample;
    logic [DATA_W-1:0] w_tx_shl;
    logic [DATA_W:0]   w_rx_cat;
    logic w_unused;

    assign w_sel_tx   = (IOBUS_ADDR == BASE_ADDR);
    assign w_sel_rx   = (IOBUS_ADDR == BASE_ADDR + 32'h4);
    assign w_sel_st   = (IOBUS_ADDR == BASE_ADDR + 32'h8);
    assign w_sel_ctrl = (IOBUS_ADDR == BASE_ADDR + 32'hC);
    assign w_unused   = ^IOBUS_OUT;

    assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);

    assign w_hdone   = (r_hcnt == r_div_l);
    // A new frame is pulled from TX either from IDLE or at the end of LAST (back-to-back).
    assign w_tx_pop  = r_en && !w_tx_empty &&
                       (r_state == S_IDLE || (r_state == S_LAST && w_hdone));
    assign w_tx_wr   = IOBUS_WR && w_sel_tx;
    assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = IOBUS_WR && w_sel_rx && !w_rx_empty;
    assign w_rx_done = (r_state == S_LAST) && w_hdone;
    assign w_rx_push = w_rx_done && (!w_rx_full || w_rx_pop);

    assign w_sin    = w_loop ? r_sdo : SPI_SDI;
    assign w_tx_shl = r_tx << 1;
    assign w_rx_cat = {r_rx, w_sin};
    // Leading edges are even toggle indices; CPHA picks whether they sample or shift.
    assign w_sample = (r_tog[0] == 1'b0) ^ r_cpha_l;

`ifdef SPI_LOOPBACK_EN
    logic r_loop;
    always_ff @(posedge CLK) begin
        if (RST)                        r_loop <= 1'b0;
        else if (IOBUS_WR && w_sel_ctrl) r_loop <= IOBUS_OUT[24];
    end
    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [3:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (sel == 4'(i)) v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] sat8(input logic [CW-1:0] c);
        logic [31:0] v;
        v = 32'(c);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div    <= RESET_DIV;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_en     <= 1'b0;
            r_cs_sel <= 4'd0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (IOBUS_WR && w_sel_ctrl) begin
                r_div    <= IOBUS_OUT[15:0];
                r_cpol   <= IOBUS_OUT[16];
                r_cpha   <= IOBUS_OUT[17];
                r_en     <= IOBUS_OUT[18];
                r_cs_sel <= IOBUS_OUT[22:19];
            end
            if (IOBUS_WR && w_sel_st && IOBUS_OUT[5]) r_tx_ovf <= 1'b0;
            if (IOBUS_WR && w_sel_st && IOBUS_OUT[6]) r_rx_ovf <= 1'b0;
            if (w_tx_wr && !w_tx_push)                r_tx_ovf <= 1'b1;
            if (w_rx_done && !w_rx_push)              r_rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= IOBUS_OUT[DATA_W-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_wr <= '0; r_tx_rd <= '0; r_tx_cnt <= '0;
            r_rx_wr <= '0; r_rx_rd <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_sclk   <= 1'b0;
            r_sdo    <= 1'b0;
            r_cs     <= '1;
            r_hcnt   <= '0;
            r_tog    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_div_l  <= '0;
            r_cpha_l <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sclk <= r_cpol;
                    r_sdo  <= 1'b0;
                    r_cs   <= '1;
                    r_hcnt <= '0;
                    if (w_tx_pop) begin
                        r_tx     <= r_tx_mem[r_tx_rd];
                        r_rx     <= '0;
                        r_tog    <= '0;
                        r_div_l  <= r_div;
                        r_cpha_l <= r_cpha;
                        r_cs     <= cs_decode(r_cs_sel);
                        r_sdo    <= r_cpha ? 1'b0 : r_tx_mem[r_tx_rd][DATA_W-1];
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (w_hdone) begin
                        r_hcnt <= '0;
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + 1'b1;
                        if (w_sample) begin
                            r_rx <= w_rx_cat[DATA_W-1:0];
                        end else begin
                            r_tx  <= w_tx_shl;
                            r_sdo <= r_cpha_l ? r_tx[DATA_W-1] : w_tx_shl[DATA_W-1];
                        end
                        r_state <= (r_tog == 7'(2*DATA_W-1)) ? S_LAST : S_SHIFT;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_LAST: begin
                    if (w_hdone) begin
                        r_hcnt <= '0;
                        if (w_tx_pop) begin
                            r_tx     <= r_tx_mem[r_tx_rd];
                            r_rx     <= '0;
                            r_tog    <= '0;
                            r_div_l  <= r_div;
                            r_cpha_l <= r_cpha;
                            r_sclk   <= r_cpol;
                            r_sdo    <= r_cpha ? 1'b0 : r_tx_mem[r_tx_rd][DATA_W-1];
                            r_state  <= S_SETUP;
                        end else begin
                            r_cs    <= '1;
                            r_sdo   <= 1'b0;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_hdone) begin
                        r_hcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        if (w_sel_rx) begin
            if (!w_rx_empty) IOBUS_IN[DATA_W-1:0] = r_rx_mem[r_rx_rd];
        end else if (w_sel_st) begin
            IOBUS_IN = {8'd0, sat8(r_rx_cnt), sat8(r_tx_cnt), 1'b0, r_rx_ovf, r_tx_ovf,
                        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, (r_state != S_IDLE)};
        end else if (w_sel_ctrl) begin
            IOBUS_IN = {7'd0, w_loop, 1'b0, r_cs_sel, r_en, r_cpha, r_cpol, r_div};
        end
    end

    assign SPI_SCLK = r_sclk;
    assign SPI_SDO  = r_sdo;
    assign SPI_CS   = r_cs;
endmodule

// File: tb/tb_mmio_spi_ctrl.sv
// Directed bench for mmio_spi_ctrl with a byte-wide SPI slave model on the pins.
module tb_mmio_spi_ctrl;
    localparam logic [31:0] BASE = 32'h1120_0000;
    localparam logic [31:0] A_TX = BASE, A_RX = BASE + 32'h4, A_ST = BASE + 32'h8, A_CT = BASE + 32'hC;

    logic        CLK = 1'b0, RST = 1'b1;
    logic [31:0] IOBUS_ADDR = '0, IOBUS_OUT = '0, IOBUS_IN;
    logic        IOBUS_WR = 1'b0;
    logic        SPI_SCLK, SPI_SDO, sdi = 1'b0;
    logic [0:0]  SPI_CS;

    mmio_spi_ctrl dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SPI_SCLK(SPI_SCLK),
        .SPI_SDO(SPI_SDO), .SPI_SDI(sdi), .SPI_CS(SPI_CS)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0;
    int edges[$];
    int rise_cnt = 0, cs_rise = 0, slv_cnt = 0, mosi_cnt = 0;
    logic [7:0] slv_q[$], mosi_q[$];
    logic [7:0] slv_sr = '0, mosi = '0;
    logic mon_cpol = 1'b0, mon_cpha = 1'b0, preloaded = 1'b0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, lead;
    logic [31:0] rd;

    always @(posedge CLK) cyc++;

    function automatic logic [7:0] next_slv();
        if (slv_q.size() == 0) return 8'h00;
        return slv_q.pop_front();
    endfunction

    // Slave: shifts on its own drive edge, reloads per byte, and records MOSI bytes.
    always @(negedge CLK) begin
        if (!SPI_CS[0] && prev_cs) begin
            slv_cnt = 0; mosi_cnt = 0;
            if (!mon_cpha) begin
                if (!preloaded) slv_sr = next_slv();
                preloaded = 1'b0;
                sdi = slv_sr[7];
            end
        end
        if (SPI_CS[0] && !prev_cs) cs_rise++;
        if (SPI_SCLK !== prev_sclk && !SPI_CS[0]) begin
            edges.push_back(cyc);
            if (SPI_SCLK) rise_cnt++;
            lead = (SPI_SCLK != mon_cpol);
            if (lead != mon_cpha) begin
                mosi = {mosi[6:0], SPI_SDO};
                mosi_cnt++;
                if (mosi_cnt == 8) begin mosi_q.push_back(mosi); mosi_cnt = 0; end
            end
            if (!mon_cpha && !lead) begin
                slv_cnt++;
                if (slv_cnt == 8) begin slv_cnt = 0; slv_sr = next_slv(); preloaded = 1'b1; end
                else slv_sr = slv_sr << 1;
                sdi = slv_sr[7];
            end
            if (mon_cpha && lead) begin
                if (slv_cnt == 0) slv_sr = next_slv();
                sdi = slv_sr[7];
                slv_sr = slv_sr << 1;
                slv_cnt = (slv_cnt + 1) % 8;
            end
        end
        prev_cs = SPI_CS[0];
        prev_sclk = SPI_SCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Bus tasks are entered at a negedge; consecutive writes hit consecutive posedges.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
        @(negedge CLK);
        IOBUS_WR = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_WR = 1'b0; IOBUS_ADDR = a;
        #1 d = IOBUS_IN;
        IOBUS_ADDR = '0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        int to;
        to = 1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < budget; i++) begin
            bus_rd(A_ST, s);
            if (!s[0]) begin to = 0; break; end
            @(negedge CLK);
        end
        @(negedge CLK);
        check("idle_timeout", 32'(to), 32'd0);
    endtask

    task automatic mon_reset(input logic cpol, input logic cpha);
        mon_cpol = cpol; mon_cpha = cpha;
        slv_q.delete(); mosi_q.delete(); edges.delete();
        preloaded = 1'b0; rise_cnt = 0; cs_rise = 0; slv_cnt = 0; mosi_cnt = 0; sdi = 1'b0;
    endtask

    initial begin
        int bad;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Reset defaults
        bus_rd(A_CT, rd); check("rst_ctrl", rd, 32'h0000_0031);
        bus_rd(A_ST, rd); check("rst_status", rd, 32'h0000_0014);
        bus_rd(A_TX, rd); check("rst_txdata_rd", rd, 32'h0);
        bus_rd(BASE + 32'h10, rd); check("unmapped_rd", rd, 32'h0);
        check("rst_cs", 32'(SPI_CS), 32'h1);
        check("rst_sclk", 32'(SPI_SCLK), 32'h0);
        check("rst_sdo", 32'(SPI_SDO), 32'h0);

        // Mode 0 single frame, DIV=1
        bus_wr(A_CT, 32'h0004_0001);
        mon_reset(1'b0, 1'b0);
        slv_q.push_back(8'h3C);
        bus_wr(A_TX, 32'h0000_00A5);
        wait_idle(200);
        check("m0_rising", 32'(rise_cnt), 32'd8);
        check("m0_edges", 32'(edges.size()), 32'd16);
        bad = 0;
        for (int i = 1; i < edges.size(); i++) if (edges[i] - edges[i-1] != 2) bad++;
        check("m0_halfper", 32'(bad), 32'd0);
        check("m0_mosi", 32'(mosi_q.size() > 0 ? mosi_q[0] : 8'h00), 32'h0000_00A5);
        check("m0_cs_rise", 32'(cs_rise), 32'd1);
        bus_rd(A_ST, rd); check("m0_status", rd, 32'h0001_0004);
        bus_rd(A_RX, rd); check("m0_rx", rd, 32'h0000_003C);
        bus_wr(A_RX, 32'h0);

        // Mode 3 burst of three frames
        bus_wr(A_CT, 32'h0007_0001);
        mon_reset(1'b1, 1'b1);
        @(negedge CLK);
        check("m3_sclk_idle", 32'(SPI_SCLK), 32'h1);
        slv_q.push_back(8'hC1); slv_q.push_back(8'h5E); slv_q.push_back(8'h99);
        bus_wr(A_TX, 32'h01); bus_wr(A_TX, 32'h02); bus_wr(A_TX, 32'h03);
        wait_idle(400);
        check("m3_cs_rise", 32'(cs_rise), 32'd1);
        check("m3_edges", 32'(edges.size()), 32'd48);
        check("m3_sclk_end", 32'(SPI_SCLK), 32'h1);
        check("m3_mosi_n", 32'(mosi_q.size()), 32'd3);
        check("m3_mosi_last", 32'(mosi_q.size() == 3 ? mosi_q[2] : 8'h00), 32'h03);
        bus_rd(A_ST, rd); check("m3_rxcnt", 32'(rd[23:16]), 32'd3);
        bus_rd(A_RX, rd); check("m3_rx0", rd, 32'hC1); bus_wr(A_RX, 32'h0);
        bus_rd(A_RX, rd); check("m3_rx1", rd, 32'h5E); bus_wr(A_RX, 32'h0);
        bus_rd(A_RX, rd); check("m3_rx2", rd, 32'h99); bus_wr(A_RX, 32'h0);

        // DIV changed 1->3 during frame 1 of a back-to-back pair
        bus_wr(A_CT, 32'h0004_0001);
        mon_reset(1'b0, 1'b0);
        @(negedge CLK);
        slv_q.push_back(8'h81); slv_q.push_back(8'h7E);
        bus_wr(A_TX, 32'h11); bus_wr(A_TX, 32'h22);
        for (int i = 0; i < 400 && rise_cnt < 2; i++) @(negedge CLK);
        bus_wr(A_CT, 32'h0004_0003);
        wait_idle(400);
        check("div_edges", 32'(edges.size()), 32'd32);
        bad = 0;
        for (int i = 1; i < 16 && i < edges.size(); i++) if (edges[i] - edges[i-1] != 2) bad++;
        check("div_frame1", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 17; i < edges.size(); i++) if (edges[i] - edges[i-1] != 4) bad++;
        check("div_frame2", 32'(bad), 32'd0);
        bus_rd(A_RX, rd); check("div_rx0", rd, 32'h81); bus_wr(A_RX, 32'h0);
        bus_rd(A_RX, rd); check("div_rx1", rd, 32'h7E); bus_wr(A_RX, 32'h0);

        // TX overflow with EN=0, then push+pop on a full FIFO, then RX overflow
        bus_wr(A_CT, 32'h0000_0000);
        mon_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) slv_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 9; i++) bus_wr(A_TX, 32'(i));
        bus_rd(A_ST, rd); check("txovf_status", rd, 32'h0000_0832);
        bus_wr(A_ST, 32'h20);
        bus_rd(A_ST, rd); check("txovf_clear", rd, 32'h0000_0812);
        bus_wr(A_CT, 32'h0004_0000);
        bus_wr(A_TX, 32'h0000_0009);
        bus_rd(A_ST, rd); check("full_pushpop", rd, 32'h0000_0813);
        wait_idle(2000);
        bus_rd(A_ST, rd); check("rxovf_status", rd, 32'h0008_004C);
        for (int i = 0; i < 8; i++) begin
            bus_rd(A_RX, rd); check("rxovf_word", rd, 32'(8'h40 + i));
            bus_wr(A_RX, 32'h0);
        end
        bus_wr(A_RX, 32'h0);
        bus_rd(A_RX, rd); check("rx_empty_rd", rd, 32'h0);
        bus_rd(A_ST, rd); check("rx_empty_pop", rd, 32'h0000_0054);
        bus_wr(A_ST, 32'h40);
        bus_rd(A_ST, rd); check("rxovf_clear", rd, 32'h0000_0014);

        // Reset asserted during bit 4 of a frame
        bus_wr(A_CT, 32'h0004_0001);
        mon_reset(1'b0, 1'b0);
        bus_wr(A_TX, 32'h77); bus_wr(A_TX, 32'h66);
        for (int i = 0; i < 400 && rise_cnt < 4; i++) @(negedge CLK);
        check("mid_cs_low", 32'(SPI_CS), 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_cs", 32'(SPI_CS), 32'h1);
        check("mid_rst_sclk", 32'(SPI_SCLK), 32'h0);
        check("mid_rst_sdo", 32'(SPI_SDO), 32'h0);
        bus_rd(A_ST, rd); check("mid_rst_status", rd, 32'h0000_0014);
        bus_rd(A_CT, rd); check("mid_rst_ctrl", rd, 32'h0000_0031);

        // Loopback with SDI held low
        mon_reset(1'b0, 1'b0);
        bus_wr(A_CT, 32'h0104_0001);
        bus_wr(A_TX, 32'h5A);
        wait_idle(200);
        bus_rd(A_CT, rd);
`ifdef SPI_LOOPBACK_EN
        check("lb_ctrl", rd, 32'h0104_0001);
        bus_rd(A_RX, rd); check("lb_rx", rd, 32'h5A);
`else
        check("lb_ctrl", rd, 32'h0004_0001);
        bus_rd(A_RX, rd); check("lb_rx", rd, 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
